// File: rtl/disp8_arbiter_pkg.sv
// Shared constants for the 8-digit display arbiter.
// State codes, blank nibble, source indices, round-robin pick.
package disp8_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALARM = 2'd1;
  localparam logic [1:0] ST_SHOW1 = 2'd2;
  localparam logic [1:0] ST_SHOW2 = 2'd3;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [31:0] BLANK_WORD = {8{BLANK}};

  localparam logic [1:0] SRC_ALARM = 2'd0;
  localparam logic [1:0] SRC_RR1   = 2'd1;
  localparam logic [1:0] SRC_RR2   = 2'd2;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  dp;
  } frame_t;

  // Prefer the requester that was not shown last.
  function automatic logic [1:0] rr_pick(
    input logic       r1,
    input logic       r2,
    input logic [1:0] last
  );
    if (r1 && r2)
      return (last == SRC_RR1) ? ST_SHOW2 : ST_SHOW1;
    else if (r1)
      return ST_SHOW1;
    else if (r2)
      return ST_SHOW2;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/disp8_arbiter_prescaler.sv
// Free-running timebase: tick is high for one clk per TICK_DIV.
// Ports: clk, rst (sync, active-high), tick.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/disp8_arbiter.sv
// Alarm-priority, round-robin arbiter for an 8-digit display.
// Ports: clk, rst, req[2:0], dat0-2, dp0-2 -> gnt, d_out, dp_out.
module disp8_arbiter #(
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 2000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [31:0] dat0,
  input  logic [31:0] dat1,
  input  logic [31:0] dat2,
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
  input  logic [7:0]  dp2,
  output logic [2:0]  gnt,
  output logic [31:0] d_out,
  output logic [7:0]  dp_out
);

  import disp8_arbiter_pkg::*;

  localparam int DW = (DWELL_TICKS > 0) ?
                      $clog2(DWELL_TICKS + 1) : 1;
  localparam int BW = (BLINK_TICKS > 1) ?
                      $clog2(BLINK_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic          tick;
  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [1:0]    rr_last;
  logic [DW-1:0] dwell;
  logic [BW-1:0] bcnt;
  logic          blink_on;
  logic          dwell_done;
  logic          is_show;
  logic          enter;
  frame_t        frame;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign is_show    = (state == ST_SHOW1) ||
                      (state == ST_SHOW2);
  assign dwell_done = (dwell == DWELL_MAX);
  assign enter      = (nxt != state);

  always_comb begin
    nxt = state;
    if (req[SRC_ALARM]) begin
      nxt = ST_ALARM;
    end else begin
      unique case (state)
        ST_IDLE,
        ST_ALARM:
          nxt = rr_pick(req[1], req[2], rr_last);
        ST_SHOW1:
          if (!req[SRC_RR1])
            nxt = rr_pick(req[1], req[2], rr_last);
          else if (dwell_done && req[SRC_RR2])
            nxt = ST_SHOW2;
        ST_SHOW2:
          if (!req[SRC_RR2])
            nxt = rr_pick(req[1], req[2], rr_last);
          else if (dwell_done && req[SRC_RR1])
            nxt = ST_SHOW1;
      endcase
    end
  end

  always_comb begin
    gnt = 3'b000;
    unique case (state)
      ST_IDLE:  gnt = 3'b000;
      ST_ALARM: gnt = 3'b001;
      ST_SHOW1: gnt = 3'b010;
      ST_SHOW2: gnt = 3'b100;
    endcase
  end

  // Source of the frame for the state currently granted.
  always_comb begin
    frame = '{d: BLANK_WORD, dp: 8'h00};
    unique case (1'b1)
      state == ST_SHOW1:
        frame = '{d: dat1, dp: dp1};
      state == ST_SHOW2:
        frame = '{d: dat2, dp: dp2};
      state == ST_ALARM && blink_on:
        frame = '{d: dat0, dp: dp0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_last  <= SRC_RR2;
      dwell    <= '0;
      bcnt     <= '0;
      blink_on <= 1'b1;
      d_out    <= BLANK_WORD;
      dp_out   <= 8'h00;
    end else begin
      state <= nxt;

      if (enter && nxt == ST_SHOW1)
        rr_last <= SRC_RR1;
      else if (enter && nxt == ST_SHOW2)
        rr_last <= SRC_RR2;

      // Expiry always clears: either a switch or a restart.
      if (enter || (is_show && dwell_done))
        dwell <= '0;
      else if (is_show && tick)
        dwell <= dwell + DW'(1);

      if (enter && nxt == ST_ALARM) begin
        blink_on <= 1'b1;
        bcnt     <= '0;
      end else if (state == ST_ALARM && tick) begin
        if (bcnt == BLINK_LAST) begin
          bcnt     <= '0;
          blink_on <= ~blink_on;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end

      d_out  <= frame.d;
      dp_out <= frame.dp;
    end
  end

endmodule

// File: tb/tb_disp8_arbiter.sv
// Scoreboard bench for disp8_arbiter with a short timebase.
// Expected frames are queued by cycle and checked at negedge.
module tb_disp8_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] dat0, dat1, dat2;
  logic [7:0]  dp0, dp1, dp2;
  logic [2:0]  gnt;
  logic [31:0] d_out;
  logic [7:0]  dp_out;

  localparam logic [31:0] BW  = 32'hFFFF_FFFF;
  localparam logic [31:0] D0  = 32'h1234_5678;
  localparam logic [31:0] D1  = 32'h1111_1111;
  localparam logic [31:0] D2  = 32'h2222_2222;
  localparam logic [31:0] D1B = 32'h1357_9BDF;
  localparam logic [7:0]  P0  = 8'hA5;
  localparam logic [7:0]  P1  = 8'h01;
  localparam logic [7:0]  P2  = 8'h02;

  typedef struct {
    int          cyc;
    logic [2:0]  g;
    bit          cd;
    logic [31:0] d;
    logic [7:0]  dp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  disp8_arbiter #(
    .TICK_DIV   (4),
    .DWELL_TICKS(3),
    .BLINK_TICKS(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dat0  (dat0),
    .dat1  (dat1),
    .dat2  (dat2),
    .dp0   (dp0),
    .dp1   (dp1),
    .dp2   (dp2),
    .gnt   (gnt),
    .d_out (d_out),
    .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL stale: cycle %0d expectation seen at %0d",
                 e.cyc, cyc);
      end else if (gnt !== e.g ||
                   (e.cd && (d_out !== e.d ||
                             dp_out !== e.dp))) begin
        errors++;
        $display("FAIL cyc%0d: got gnt=%b d=%h dp=%h, want gnt=%b d=%h dp=%h (d checked=%0d)",
                 cyc, gnt, d_out, dp_out, e.g, e.d, e.dp, e.cd);
      end
    end
  end

  task automatic exp(input int c, input logic [2:0] g,
                     input bit cd, input logic [31:0] d,
                     input logic [7:0] dp);
    exp_t t;
    t.cyc = c;
    t.g   = g;
    t.cd  = cd;
    t.d   = d;
    t.dp  = dp;
    sb.push_back(t);
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    dat0 = D0;
    dat1 = D1;
    dat2 = D2;
    dp0  = P0;
    dp1  = P1;
    dp2  = P2;

    // reset state, then idle with no requests
    for (int c = 2; c <= 8; c++)
      exp(c, 3'b000, 1, BW, 8'h00);
    go_to(2);
    rst = 1'b0;
    go_to(7);
    rst = 1'b1;

    // both round-robin sources from reset: 12 clk dwell
    exp(9,  3'b010, 1, BW, 8'h00);
    exp(10, 3'b010, 1, D1, P1);
    exp(20, 3'b010, 1, D1, P1);
    exp(21, 3'b100, 1, D1, P1);
    exp(22, 3'b100, 1, D2, P2);
    exp(32, 3'b100, 1, D2, P2);
    exp(33, 3'b010, 1, D2, P2);
    exp(34, 3'b010, 1, D1, P1);
    go_to(8);
    rst = 1'b0;
    req = 3'b110;

    // source 1 alone: dwell expiry holds the grant
    go_to(34);
    req = 3'b010;
    exp(44, 3'b010, 1, D1, P1);
    exp(45, 3'b010, 1, D1, P1);
    exp(47, 3'b010, 1, D1B, P1);
    exp(48, 3'b010, 1, D1, P1);
    exp(57, 3'b010, 1, D1, P1);
    exp(58, 3'b010, 1, D1, P1);
    go_to(46);
    dat1 = D1B;
    go_to(47);
    dat1 = D1;

    // rotate to source 2, alarm on its dwell-expiry cycle
    go_to(58);
    req = 3'b110;
    exp(68,  3'b010, 1, D1, P1);
    exp(69,  3'b100, 1, D1, P1);
    exp(80,  3'b100, 1, D2, P2);
    exp(81,  3'b001, 1, D2, P2);
    exp(82,  3'b001, 1, D0, P0);
    exp(88,  3'b001, 1, D0, P0);
    exp(89,  3'b001, 1, BW, 8'h00);
    exp(96,  3'b001, 1, BW, 8'h00);
    exp(97,  3'b001, 1, D0, P0);
    exp(104, 3'b001, 1, D0, P0);
    exp(105, 3'b001, 1, BW, 8'h00);
    go_to(80);
    req = 3'b111;

    // alarm released, rr_last=2 -> source 1
    exp(106, 3'b001, 1, BW, 8'h00);
    exp(107, 3'b010, 1, BW, 8'h00);
    exp(108, 3'b010, 1, D1, P1);
    go_to(106);
    req = 3'b110;

    // one-cycle reset pulse while showing source 1
    exp(111, 3'b000, 1, BW, 8'h00);
    exp(112, 3'b010, 1, BW, 8'h00);
    exp(113, 3'b010, 1, D1, P1);
    go_to(110);
    rst = 1'b1;
    go_to(111);
    rst = 1'b0;

    // source 1 drops: hand over to 2, then idle
    exp(115, 3'b100, 1, D1, P1);
    exp(116, 3'b100, 1, D2, P2);
    exp(117, 3'b000, 1, D2, P2);
    exp(118, 3'b000, 1, BW, 8'h00);
    go_to(114);
    req = 3'b100;
    go_to(116);
    req = 3'b000;

    go_to(120);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
